// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg: shared CBus request/response types and burst length encodings.
package cbus_arbiter_pkg;
  typedef enum logic [3:0] {
    MLEN1  = 4'b0000,
    MLEN2  = 4'b0001,
    MLEN4  = 4'b0011,
    MLEN8  = 4'b0111,
    MLEN16 = 4'b1111
  } mlen_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    mlen_t       len;
    logic [3:0]  strobe;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// cbus_arbiter_rr_picker: combinational circular priority scan starting at i_start.
module cbus_arbiter_rr_picker #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_start,
  output logic         o_any,
  output logic [W-1:0] o_idx
);
  logic [W-1:0] w_cand;
  always_comb begin
    o_any = |i_valid;
    o_idx = '0;
    w_cand = '0;
    // Scan from the far end back so the candidate closest to i_start wins.
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = W'((int'(i_start) + k) % N);
      if (i_valid[w_cand]) o_idx = w_cand;
    end
  end
endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin merge of several CBus masters onto one port; the
// owner keeps the port until the last response beat of its burst.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);
  localparam int W = $clog2(NUM_INPUTS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_owner, r_rr, w_idx;
  cbus_req_t r_saved;
  logic [NUM_INPUTS-1:0] w_valid;
  logic w_any, w_done;
  always_comb for (int i = 0; i < NUM_INPUTS; i++) w_valid[i] = ireqs[i].valid;
  cbus_arbiter_rr_picker #(.N(NUM_INPUTS)) u_picker (
    .i_valid(w_valid),
    .i_start(r_rr),
    .o_any  (w_any),
    .o_idx  (w_idx)
  );
  assign w_done = oresp.ready && oresp.last;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = r_state == IDLE ? (w_any ? BUSY : IDLE) : (w_done ? IDLE : BUSY);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_owner <= '0;
      r_rr    <= '0;
      r_saved <= '0;
    end else if (r_state == IDLE && w_any) begin
      r_saved <= ireqs[w_idx];
      r_owner <= w_idx;
    end else if (r_state == BUSY && w_done) begin
      r_rr <= r_owner == W'(NUM_INPUTS - 1) ? '0 : r_owner + 1'b1;
    end
  always_comb begin
    oreq = r_state == BUSY ? r_saved : '0;
    oreq.valid = r_state == BUSY;
    for (int i = 0; i < NUM_INPUTS; i++)
      iresps[i] = (r_state == BUSY && r_owner == W'(i)) ? oresp : '0;
  end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of ownership and round-robin order.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;
  localparam int N = 2;
  logic clk = 0;
  logic resetn = 0;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  int checks = 0;
  int failures = 0;
  bit m_busy;
  int m_owner, m_rr;
  cbus_req_t m_req;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps), .oreq(oreq), .oresp(oresp)
  );

  function automatic cbus_req_t rd(logic [31:0] a, mlen_t l);
    cbus_req_t r = '0;
    r.valid = 1'b1; r.addr = a; r.len = l; r.size = 3'd2; r.strobe = 4'hf;
    return r;
  endfunction

  function automatic cbus_resp_t beat(logic last, logic [31:0] d);
    cbus_resp_t r;
    r.ready = 1'b1; r.last = last; r.data = d;
    return r;
  endfunction

  function automatic cbus_req_t rand_req(logic v);
    cbus_req_t r;
    r.valid = v;
    r.is_write = 1'($urandom);
    r.size = 3'($urandom_range(0, 2));
    r.addr = $urandom;
    r.data = $urandom;
    r.strobe = 4'($urandom);
    case ($urandom_range(0, 2))
      0: r.len = MLEN1;
      1: r.len = MLEN2;
      default: r.len = MLEN4;
    endcase
    return r;
  endfunction

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn = 0;
    for (int m = 0; m < N; m++) ireqs[m] = '0;
    oresp = '0;
    m_busy = 0; m_owner = 0; m_rr = 0; m_req = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic test_reset;
    ireqs[0] = rand_req(1'b1);
    ireqs[1] = rand_req(1'b1);
    oresp = beat(1'b1, 32'hA5A5_A5A5);
    #2;
    checks++; if (oreq !== '0) begin failures++; $display("FAIL reset_oreq got=%h exp=0", oreq); end
    for (int m = 0; m < N; m++) begin
      checks++; if (iresps[m] !== '0) begin failures++; $display("FAIL reset_iresp%0d got=%h exp=0", m, iresps[m]); end
    end
    nxt; #2;
    checks++; if (oreq !== '0) begin failures++; $display("FAIL reset_hold_oreq got=%h exp=0", oreq); end
  endtask

  task automatic test_single;
    do_reset;
    ireqs[0] = rd(32'h8000_0000, MLEN1);
    #2;
    checks++; if (oreq.valid !== 1'b0) begin failures++; $display("FAIL single_nocomb got=%b exp=0", oreq.valid); end
    nxt; ireqs[0] = '0; #2;
    checks++; if (oreq !== rd(32'h8000_0000, MLEN1)) begin failures++; $display("FAIL single_grant got=%h exp=%h", oreq, rd(32'h8000_0000, MLEN1)); end
    checks++; if (iresps[0] !== '0) begin failures++; $display("FAIL single_noresp got=%h exp=0", iresps[0]); end
    nxt; oresp = beat(1'b1, 32'hDEAD_BEEF); #2;
    checks++; if (iresps[0] !== beat(1'b1, 32'hDEAD_BEEF)) begin failures++; $display("FAIL single_last got=%h exp=%h", iresps[0], beat(1'b1, 32'hDEAD_BEEF)); end
    checks++; if (iresps[1] !== '0) begin failures++; $display("FAIL single_other got=%h exp=0", iresps[1]); end
    nxt; oresp = '0; #2;
    checks++; if (oreq.valid !== 1'b0) begin failures++; $display("FAIL single_bubble got=%b exp=0", oreq.valid); end
  endtask

  task automatic test_tie;
    do_reset;
    ireqs[0] = rd(32'h0000_1000, MLEN1);
    ireqs[1] = rd(32'h0000_2000, MLEN1);
    nxt; ireqs[0] = '0; oresp = beat(1'b1, 32'h1111_1111); #2;
    checks++; if (oreq !== rd(32'h0000_1000, MLEN1)) begin failures++; $display("FAIL tie_first got=%h exp=%h", oreq, rd(32'h0000_1000, MLEN1)); end
    checks++; if (iresps[0].data !== 32'h1111_1111) begin failures++; $display("FAIL tie_resp0 got=%h exp=11111111", iresps[0].data); end
    checks++; if (iresps[1] !== '0) begin failures++; $display("FAIL tie_resp1_quiet got=%h exp=0", iresps[1]); end
    nxt; oresp = '0; #2;
    checks++; if (oreq.valid !== 1'b0) begin failures++; $display("FAIL tie_bubble got=%b exp=0", oreq.valid); end
    nxt; ireqs[1] = '0; oresp = beat(1'b1, 32'h2222_2222); #2;
    checks++; if (oreq !== rd(32'h0000_2000, MLEN1)) begin failures++; $display("FAIL tie_second got=%h exp=%h", oreq, rd(32'h0000_2000, MLEN1)); end
    checks++; if (iresps[1] !== beat(1'b1, 32'h2222_2222)) begin failures++; $display("FAIL tie_resp1 got=%h exp=%h", iresps[1], beat(1'b1, 32'h2222_2222)); end
    checks++; if (iresps[0] !== '0) begin failures++; $display("FAIL tie_resp0_quiet got=%h exp=0", iresps[0]); end
    nxt; oresp = '0;
  endtask

  task automatic test_fairness;
    do_reset;
    ireqs[0] = rd(32'h0000_1000, MLEN1);
    ireqs[1] = rd(32'h0000_2000, MLEN1);
    for (int t = 0; t < 6; t++) begin
      #2;
      checks++; if (oreq.valid !== 1'b0) begin failures++; $display("FAIL fair_idle%0d got=%b exp=0", t, oreq.valid); end
      nxt; oresp = beat(1'b1, 32'(t)); #2;
      checks++; if (oreq.addr !== 32'h1000 * (t % 2 + 1)) begin failures++; $display("FAIL fair_owner%0d got=%h exp=%h", t, oreq.addr, 32'h1000 * (t % 2 + 1)); end
      checks++; if (iresps[t % 2].data !== 32'(t) || iresps[1 - t % 2] !== '0) begin failures++; $display("FAIL fair_route%0d got=%h/%h exp_owner=%0d", t, iresps[0], iresps[1], t % 2); end
      nxt; oresp = '0;
    end
  endtask

  task automatic test_burst;
    do_reset;
    ireqs[1] = rd(32'h0000_3000, MLEN4);
    nxt;
    ireqs[1].valid = 1'b0;
    ireqs[0] = rd(32'h0000_4000, MLEN1);
    for (int b = 1; b <= 4; b++) begin
      ireqs[1].addr = $urandom;
      oresp = beat(b == 4, 32'hB000 + 32'(b));
      #2;
      checks++; if (oreq !== rd(32'h0000_3000, MLEN4)) begin failures++; $display("FAIL burst_oreq%0d got=%h exp=%h", b, oreq, rd(32'h0000_3000, MLEN4)); end
      checks++; if (iresps[1] !== beat(b == 4, 32'hB000 + 32'(b))) begin failures++; $display("FAIL burst_beat%0d got=%h exp=%h", b, iresps[1], beat(b == 4, 32'hB000 + 32'(b))); end
      checks++; if (iresps[0] !== '0) begin failures++; $display("FAIL burst_other%0d got=%h exp=0", b, iresps[0]); end
      nxt;
    end
    oresp = '0; #2;
    checks++; if (oreq.valid !== 1'b0) begin failures++; $display("FAIL burst_bubble got=%b exp=0", oreq.valid); end
    nxt; ireqs[0] = '0; #2;
    checks++; if (oreq !== rd(32'h0000_4000, MLEN1)) begin failures++; $display("FAIL burst_next got=%h exp=%h", oreq, rd(32'h0000_4000, MLEN1)); end
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    ireqs[1] = rd(32'h0000_5000, MLEN4);
    nxt; ireqs[1] = '0;
    for (int b = 1; b <= 2; b++) begin
      oresp = beat(1'b0, 32'(b)); #2;
      checks++; if (iresps[1].data !== 32'(b)) begin failures++; $display("FAIL rstmid_beat%0d got=%h exp=%h", b, iresps[1].data, 32'(b)); end
      nxt;
    end
    oresp = beat(1'b0, 32'd3);
    resetn = 0;
    #1;
    checks++; if (oreq.valid !== 1'b0) begin failures++; $display("FAIL rstmid_oreq got=%b exp=0", oreq.valid); end
    checks++; if (iresps[1] !== '0) begin failures++; $display("FAIL rstmid_iresp got=%h exp=0", iresps[1]); end
    nxt; nxt;
    resetn = 1; oresp = '0;
    m_busy = 0; m_rr = 0; m_owner = 0;
    ireqs[0] = rd(32'h0000_6000, MLEN1); #2;
    checks++; if (oreq.valid !== 1'b0) begin failures++; $display("FAIL rstmid_latency got=%b exp=0", oreq.valid); end
    nxt; ireqs[0] = '0; oresp = beat(1'b1, 32'h6666_6666); #2;
    checks++; if (oreq !== rd(32'h0000_6000, MLEN1)) begin failures++; $display("FAIL rstmid_regrant got=%h exp=%h", oreq, rd(32'h0000_6000, MLEN1)); end
    checks++; if (iresps[0].data !== 32'h6666_6666) begin failures++; $display("FAIL rstmid_resp got=%h exp=66666666", iresps[0].data); end
    nxt; oresp = '0;
  endtask

  task automatic test_random;
    cbus_req_t  e_req;
    cbus_resp_t e_resp;
    do_reset;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < N; m++) ireqs[m] = rand_req(1'($urandom_range(0, 1)));
      oresp.ready = 1'($urandom_range(0, 1));
      oresp.last = $urandom_range(0, 2) == 0;
      oresp.data = $urandom;
      #2;
      e_req = m_busy ? m_req : '0;
      e_req.valid = m_busy;
      checks++; if (oreq !== e_req) begin failures++; $display("FAIL rand_oreq c=%0d got=%h exp=%h", c, oreq, e_req); end
      for (int m = 0; m < N; m++) begin
        e_resp = (m_busy && m_owner == m) ? oresp : '0;
        checks++; if (iresps[m] !== e_resp) begin failures++; $display("FAIL rand_iresp%0d c=%0d got=%h exp=%h", m, c, iresps[m], e_resp); end
      end
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (ireqs[j].valid) begin
            m_busy = 1; m_owner = j; m_req = ireqs[j];
            break;
          end
        end
      end else if (oresp.ready && oresp.last) begin
        m_busy = 0;
        m_rr = (m_owner + 1) % N;
      end
      nxt;
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_single;
    test_tie;
    test_fairness;
    test_burst;
    test_reset_mid_burst;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Round-robin arbiter merging several CBus masters (the data-side bus adapter, the instruction fetch adapter, and any uncached paths) onto the single CBus port toward the memory interconnect. It sits directly downstream of the per-master DBus/IBus-to-CBus adapters. It captures one granted request per transaction, forwards it unchanged, and routes every response beat back to the owner only. Ownership is held until the final beat of the burst completes.

## Interface
- NUM_INPUTS, default 2: number of upstream CBus masters (≥2).
- clk  in  1: clock, rising edge.
- resetn  in  1: asynchronous active-low reset.
- ireqs  in  cbus_req_t[NUM_INPUTS]: upstream requests.
- iresps  out  cbus_resp_t[NUM_INPUTS]: per-master responses.
- oreq  out  cbus_req_t: merged request to the interconnect.
- oresp  in  cbus_resp_t: interconnect response.

## Operation
- States: IDLE, BUSY. Internal registers:
  - owner index, $clog2(NUM_INPUTS) bits.
  - rr pointer: highest-priority index for the next grant.
  - saved_req: a cbus_req_t.
- IDLE:
  - oreq is all-zero (valid=0).
  - Every iresps[i] is all-zero.
  - If any ireqs[i].valid: pick the first valid index scanning circularly from rr pointer.
  - Load saved_req with that request, set owner to that index, go to BUSY.
  - If no input is valid, stay in IDLE.
- BUSY:
  - oreq = saved_req; valid is forced to 1.
  - iresps[owner] = oresp.
  - All other iresps are all-zero.
  - Changes on ireqs, including the owner's, are ignored.
- Completion:
  - In BUSY, oresp.ready && oresp.last moves the block to IDLE.
  - rr pointer ← (owner+1) mod NUM_INPUTS. The wrap from NUM_INPUTS-1 goes to 0.
- Beats with ready=1 and last=0 are passed through to the owner. They do not change state.
- oresp.ready/last are ignored in IDLE.
- saved_req fields:
  - len, size, addr, is_write and strobe are captured once per grant.
  - data is captured at grant and is not updated per beat. Multi-beat write bursts are not supported through this block; masters issue single-beat writes (len = MLEN1).

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE; owner, rr pointer and saved_req go to 0.
  - oreq and all iresps read 0 immediately.
  - A burst in flight is abandoned without completion. The interconnect is reset together with the arbiter.
- Grant latency:
  - A request valid in IDLE cycle t produces oreq.valid=1 at cycle t+1.
  - The first possible response beat is at t+1, combinationally from oresp.
- Completion:
  - The last beat at cycle u is visible on iresps[owner] at u.
  - The block is IDLE at u+1, so oreq.valid=0 at u+1.
  - The earliest next grant is evaluated at u+1, with oreq.valid again at u+2. There is exactly one idle bubble between transactions.
- Simultaneous requests: the round-robin scan decides.
  - After reset, index 0 wins ties.
  - Following a grant to i, index i+1 (circular) has highest priority.
- A master still holding valid in the cycle after its own last is treated as a new request. This is the required behaviour for back-to-back adapter traffic.
- Throughput: one transaction per (burst length + 1) cycles minimum.
- No combinational path from ireqs to oreq or iresps. There is a combinational path from oresp to iresps.

## Structure
- cbus_req_t, cbus_resp_t and the MLEN* length encodings stay in the shared common package. No new shared types are needed.
- Sub-module rr_picker:
  - Parameter N.
  - Inputs: valid vector, start pointer.
  - Outputs: any_valid, chosen index.
  - Purely combinational circular priority scan.
- State encoding is local to cbus_arbiter.

## Test plan
- Single master: ireqs[0] reads addr 0x8000_0000, len MLEN1. oresp gives ready=last=1 with data 0xDEADBEEF two cycles later. Required:
  - oreq.valid rises one cycle after the request.
  - iresps[0].data=0xDEADBEEF on the last cycle.
  - iresps[1] stays 0.
  - oreq.valid=0 on the following cycle.
- Tie after reset: both masters valid in the same cycle. Required:
  - Master 0 is served first.
  - After its last, master 1 gets oreq.valid at u+2 with its own address.
- Round-robin fairness: both masters continuously valid for 6 single-beat transactions. Required: owners alternate 0,1,0,1,0,1.
- Burst: master 1 issues len MLEN4 with 4 ready beats, last on beat 4. Required:
  - All 4 beats appear only on iresps[1].
  - oreq stays constant even when ireqs[1].addr changes mid-burst.
- Reset mid-burst: assert resetn=0 after beat 2 of a 4-beat burst. Required:
  - oreq.valid=0 immediately.
  - After release, a new master-0 request is granted with a 1-cycle latency.
